sseg_reader: RTL and testbench
==============================

SSEG_READER -- requirements
Module: sseg_reader

Interface
REQ-001 The module SHALL have parameter STABLE_CYCLES, default 4, meaning consecutive unchanged cycles required before a digit is sampled (legal range 2..15).
REQ-002 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  reset, synchronous and active-low (0 = reset, sampled on rising clk).
REQ-004 Port sseg  input  [0:6]  segment lines a..g (sseg[0]=a ... sseg[6]=g), active-low (0 = segment lit).
REQ-005 Port an  input  [3:0]  digit anodes, active-low one-hot; an[0] selects the least-significant digit.
REQ-006 Port num  output  [15:0]  last complete captured value; an[k] digit maps to num[4k+3:4k].
REQ-007 Port num_valid  output  1  one-cycle pulse when num is updated.
REQ-008 Port digit_err  output  1  one-cycle pulse on an invalid pattern or a non-one-hot anode.

Function
REQ-009 sseg and an SHALL be registered once (input stage) before all other logic; all timing below is relative to that stage.
REQ-010 The stability counter SHALL clear when the registered {an,sseg} differs from its previous-cycle value and otherwise increment, saturating at STABLE_CYCLES.
REQ-011 The counter reaching STABLE_CYCLES SHALL trigger exactly one sample per dwell; no re-sample until {an,sseg} changes.
REQ-012 The decoder SHALL accept only these active-high abcdefg patterns -> nibble: 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9, 1110111->A, 0011111->b, 1001110->C, 0111101->d, 1001111->E, 1000111->F (compare against inverted sseg).
REQ-013 On a sample with one-hot-low an[k] and a valid pattern, the decoded nibble SHALL be written to shadow digit k and seen-mask bit k SHALL be set.
REQ-014 On a sample with a valid an but an unlisted pattern, digit_err SHALL pulse the following cycle; shadow and mask are unchanged.
REQ-015 On a sample with an = 4'b1111 (blanked), the sample SHALL be ignored silently: no error, no write.
REQ-016 On a sample with two or more an bits low, digit_err SHALL pulse once; shadow and mask are unchanged.
REQ-017 Re-capturing an already-set digit before the frame completes SHALL overwrite that shadow nibble; the mask is unaffected.
REQ-018 When the mask becomes 4'b1111, num SHALL load all four shadow nibbles and num_valid SHALL pulse on the next cycle; the mask SHALL clear in that same cycle.
REQ-019 Latency: an input change at the pins SHALL yield its shadow write STABLE_CYCLES+1 cycles later; for the 4th digit, num_valid follows one cycle after that write.
REQ-020 num SHALL hold its value between frames; num_valid and digit_err SHALL never be high for more than one consecutive cycle per event.
REQ-021 Simultaneous frame completion and error are impossible by construction (one sample per cycle); the implementation SHALL prioritise reset > sample > hold.

Reset
REQ-022 While rst=0 at a rising edge: num=16'h0000, num_valid=0, digit_err=0, shadow=0, mask=0, stability counter=0, input register=all-ones (blank).
REQ-023 Reset asserted mid-frame SHALL discard the partial frame; capture restarts from an empty mask after release.
REQ-024 The first sample after release SHALL require a full STABLE_CYCLES dwell.

Verification
REQ-025 Drive the digits 1,2,3,4 on an[0..3] (an=1110,1101,1011,0111), 8 cycles each, STABLE_CYCLES=4 -> num=16'h4321, exactly one num_valid pulse.
REQ-026 Drive an=1110 with sseg alternating every 2 cycles, STABLE_CYCLES=4 -> no sample, no num_valid, no digit_err.
REQ-027 Drive an=1101 with sseg pattern 0000001 (only g lit, active-high) held for 8 cycles -> one digit_err pulse; mask bit 1 stays clear.
REQ-028 Drive an=1100 held for 8 cycles -> one digit_err pulse; drive an=1111 held for 8 cycles -> no pulse.
REQ-029 Capture digits 0..2 of 16'hABCD, assert rst=0 for 1 cycle, then drive a full 16'h00F0 frame -> num=16'h00F0 and only one num_valid pulse in total.
REQ-030 Hold each digit for exactly STABLE_CYCLES cycles and check num_valid timing per REQ-019; drive all 16 patterns through an[3] to cover the full decode table.

Source files
------------

// File: rtl/sseg_reader.sv
// Recovers a 4-digit hex value by watching a multiplexed, active-low 7-segment bus.
// Each digit must dwell unchanged before it is decoded; num updates once all four are seen.
module sseg_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [0:6]  sseg,
  input  logic [3:0]  an,
  output logic [15:0] num,
  output logic        num_valid,
  output logic        digit_err
);

  localparam logic [3:0] SC = 4'(STABLE_CYCLES);

  logic [3:0]      an_q;
  logic [0:6]      seg_q;
  logic [3:0]      cnt;
  logic [3:0][3:0] shadow;
  logic [3:0]      mask;

  logic       chg, sample, pat_ok, onehot, blank;
  logic [6:0] pat;
  logic [3:0] nib;
  logic [1:0] idx;

  // The counter clears on the same edge the input stage takes a new value, so
  // cnt == SC-1 means the registered value has been present for SC cycles.
  assign chg    = ({an, sseg} != {an_q, seg_q});
  assign sample = (cnt == SC - 4'd1);
  assign pat    = ~seg_q;  // active-high abcdefg, a in bit 6

  always_comb begin
    pat_ok = 1'b1;
    nib    = 4'h0;
    case (pat)
      7'b1111110: nib = 4'h0;
      7'b0110000: nib = 4'h1;
      7'b1101101: nib = 4'h2;
      7'b1111001: nib = 4'h3;
      7'b0110011: nib = 4'h4;
      7'b1011011: nib = 4'h5;
      7'b1011111: nib = 4'h6;
      7'b1110000: nib = 4'h7;
      7'b1111111: nib = 4'h8;
      7'b1111011: nib = 4'h9;
      7'b1110111: nib = 4'hA;
      7'b0011111: nib = 4'hB;
      7'b1001110: nib = 4'hC;
      7'b0111101: nib = 4'hD;
      7'b1001111: nib = 4'hE;
      7'b1000111: nib = 4'hF;
      default:    pat_ok = 1'b0;
    endcase
  end

  always_comb begin
    onehot = 1'b1;
    blank  = 1'b0;
    idx    = 2'd0;
    case (an_q)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      4'b1111: begin onehot = 1'b0; blank = 1'b1; end
      default: onehot = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      an_q      <= '1;
      seg_q     <= '1;
      cnt       <= '0;
      shadow    <= '0;
      mask      <= '0;
      num       <= '0;
      num_valid <= 1'b0;
      digit_err <= 1'b0;
    end else begin
      an_q      <= an;
      seg_q     <= sseg;
      num_valid <= 1'b0;
      digit_err <= 1'b0;
      if (chg)          cnt <= '0;
      else if (cnt != SC) cnt <= cnt + 4'd1;
      if (mask == 4'hF) begin
        num       <= shadow;
        num_valid <= 1'b1;
        mask      <= '0;
      end
      // Samples are at least SC cycles apart, so this never collides with the frame load.
      if (sample) begin
        if (onehot && pat_ok) begin
          shadow[idx] <= nib;
          mask[idx]   <= 1'b1;
        end else if (!blank) begin
          digit_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sseg_reader.sv
// Directed bench for sseg_reader with STABLE_CYCLES = 4.
module tb_sseg_reader;
  logic        clk = 1'b0;
  logic        rst;
  logic [0:6]  sseg;
  logic [3:0]  an;
  logic [15:0] num;
  logic        num_valid, digit_err;

  int cyc = 0, nv_cnt = 0, de_cnt = 0, nv_cyc = -1, de_cyc = -1;
  int n_chk = 0, n_fail = 0, t_drv = 0;
  logic nv_prev = 1'b0, de_prev = 1'b0;

  logic [6:0] segtab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                              7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                              7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                              7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  sseg_reader #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .sseg(sseg), .an(an),
    .num(num), .num_valid(num_valid), .digit_err(digit_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (num_valid) begin nv_cnt++; nv_cyc = cyc; end
    if (digit_err) begin de_cnt++; de_cyc = cyc; end
    if (num_valid && nv_prev) chk("nv_width", 1, 0);
    if (digit_err && de_prev) chk("de_width", 1, 0);
    nv_prev = num_valid;
    de_prev = digit_err;
  end

  // Applies an/pattern at a negedge and holds it for exactly n rising edges.
  task automatic drive(input logic [3:0] a, input logic [6:0] pat_ah, input int n);
    @(negedge clk);
    an    = a;
    sseg  = ~pat_ah;
    t_drv = cyc;
    repeat (n) @(posedge clk);
  endtask

  task automatic dig(input logic [3:0] a, input int d, input int n);
    drive(a, segtab[d], n);
  endtask

  initial begin
    int nv0, de0, t3;
    rst = 1'b0; an = 4'hF; sseg = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_num", num, 16'h0000);
    chk("rst_nv", num_valid, 0);
    chk("rst_de", digit_err, 0);
    rst = 1'b1;

    // Basic frame 4321
    nv0 = nv_cnt; de0 = de_cnt;
    dig(4'b1110, 1, 8); dig(4'b1101, 2, 8); dig(4'b1011, 3, 8); dig(4'b0111, 4, 8);
    drive(4'hF, 7'h00, 8);
    chk("frame_num", num, 16'h4321);
    chk("frame_nv", nv_cnt - nv0, 1);
    chk("frame_de", de_cnt - de0, 0);

    // Chattering segments never settle
    nv0 = nv_cnt; de0 = de_cnt;
    for (int i = 0; i < 8; i++) dig(4'b1110, (i % 2) ? 2 : 1, 2);
    drive(4'hF, 7'h00, 8);
    chk("chatter_nv", nv_cnt - nv0, 0);
    chk("chatter_de", de_cnt - de0, 0);
    chk("chatter_num", num, 16'h4321);

    // Unlisted pattern on digit 1, then the frame still needs digit 1
    nv0 = nv_cnt; de0 = de_cnt;
    drive(4'b1101, 7'b0000001, 8);
    t3 = t_drv;
    chk("badpat_de", de_cnt - de0, 1);
    chk("badpat_t", de_cyc, t3 + 5);
    dig(4'b1110, 5, 8); dig(4'b1011, 6, 8); dig(4'b0111, 7, 8);
    drive(4'hF, 7'h00, 8);
    chk("mask1_clear", nv_cnt - nv0, 0);
    dig(4'b1101, 8, 8);
    drive(4'hF, 7'h00, 8);
    chk("mask1_nv", nv_cnt - nv0, 1);
    chk("mask1_num", num, 16'h7685);

    // Two anodes low vs. blanked
    de0 = de_cnt;
    dig(4'b1100, 3, 8);
    drive(4'hF, 7'h00, 8);
    chk("multi_an_de", de_cnt - de0, 1);
    de0 = de_cnt;
    dig(4'b1111, 3, 8);
    drive(4'hF, 7'h00, 8);
    chk("blank_de", de_cnt - de0, 0);

    // Partial ABCD frame discarded by reset, then 00F0
    nv0 = nv_cnt;
    dig(4'b1110, 13, 8); dig(4'b1101, 12, 8); dig(4'b1011, 11, 8);
    @(negedge clk);
    rst = 1'b0; an = 4'hF; sseg = '1;
    @(negedge clk);
    chk("midrst_num", num, 16'h0000);
    rst = 1'b1;
    dig(4'b1110, 0, 8); dig(4'b1101, 15, 8); dig(4'b1011, 0, 8); dig(4'b0111, 0, 8);
    drive(4'hF, 7'h00, 8);
    chk("midrst_frame", num, 16'h00F0);
    chk("midrst_nv", nv_cnt - nv0, 1);

    // Minimum dwell, every pattern on digit 3, with exact num_valid timing
    nv0 = nv_cnt; de0 = de_cnt;
    for (int d = 0; d < 16; d++) begin
      dig(4'b1110, 1, 4); dig(4'b1101, 2, 4); dig(4'b1011, 3, 4);
      dig(4'b0111, d, 4);
      t3 = t_drv;
      drive(4'hF, 7'h00, 4);
      chk($sformatf("tab_num%0d", d), num, {d[3:0], 12'h321});
      chk($sformatf("tab_t%0d", d), nv_cyc, t3 + 6);
    end
    chk("tab_nv", nv_cnt - nv0, 16);
    chk("tab_de", de_cnt - de0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end
endmodule
